// File: rtl/elevator_sched_if.sv
// Hall/cab request and car command bundle shared between the elevator scheduler and its environment.
interface elevator_sched_if #(
  parameter int N_FLOOR = 7,
  parameter int N_CAR   = 2,
  parameter int FLOOR_W = 3
);
  logic [N_FLOOR-1:0]       up_passenger;
  logic [N_FLOOR-1:0]       down_passenger;
  logic [N_CAR*FLOOR_W-1:0] curr_floor;
  logic [N_CAR*N_FLOOR-1:0] cab_call;
  logic [N_CAR-1:0]         arrive;
  logic [N_CAR-1:0]         dir;
  logic [N_CAR-1:0]         move;
  logic [N_CAR-1:0]         door_open;
  logic [N_CAR-1:0]         turn;
  logic [N_CAR-1:0]         fault;
  logic [N_FLOOR-1:0]       clr_up;
  logic [N_FLOOR-1:0]       clr_dn;

  modport master (
    output up_passenger, down_passenger, curr_floor, cab_call, arrive,
    input  dir, move, door_open, turn, fault, clr_up, clr_dn
  );

  modport slave (
    input  up_passenger, down_passenger, curr_floor, cab_call, arrive,
    output dir, move, door_open, turn, fault, clr_up, clr_dn
  );
endinterface

// File: rtl/elevator_sched.sv
// Multi-car elevator scheduler: one independent IDLE/MOVING/DOOR controller per car,
// hall-call clear pulses from all cars ORed per floor.
module elevator_sched #(
  parameter int N_FLOOR = 7,
  parameter int N_CAR   = 2,
  parameter int FLOOR_W = 3,
  parameter int DWELL   = 3
) (
  input logic             clk,
  input logic             rst_n,
  elevator_sched_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } car_state_e;

  logic [N_FLOOR-1:0] clrUpCar [N_CAR];
  logic [N_FLOOR-1:0] clrDnCar [N_CAR];
  logic [N_FLOOR-1:0] clrUp_q, clrUp_d;
  logic [N_FLOOR-1:0] clrDn_q, clrDn_d;

  for (genvar c = 0; c < N_CAR; c++) begin : gCar
    logic [FLOOR_W-1:0] floor;
    logic [N_FLOOR-1:0] cab;
    logic [N_FLOOR-1:0] calls;
    logic               floorOk;
    logic               above, below, cabHere, upHere, dnHere, here;
    logic               eDir, ahead, behind, enterDoor, arrived;
    logic [N_FLOOR-1:0] clrUpLoc, clrDnLoc;

    car_state_e         state_q, state_d;
    logic               dir_q, dir_d;
    logic               move_q, move_d;
    logic               door_q, door_d;
    logic               turn_q, turn_d;
    logic               fault_q, fault_d;
    logic               arrPend_q, arrPend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign floor   = bus.curr_floor[c*FLOOR_W +: FLOOR_W];
    assign cab     = bus.cab_call[c*N_FLOOR +: N_FLOOR];
    assign floorOk = int'(floor) < N_FLOOR;
    assign arrived = bus.arrive[c] | arrPend_q;

    always_comb begin
      calls   = bus.up_passenger | bus.down_passenger | cab;
      above   = 1'b0;
      below   = 1'b0;
      cabHere = 1'b0;
      upHere  = 1'b0;
      dnHere  = 1'b0;
      for (int f = 0; f < N_FLOOR; f++) begin
        if (f > int'(floor)) above = above | calls[f];
        if (f < int'(floor)) below = below | calls[f];
        if (f == int'(floor)) begin
          cabHere = cab[f];
          upHere  = bus.up_passenger[f];
          dnHere  = bus.down_passenger[f];
        end
      end
      here = cabHere | upHere | dnHere;
    end

    // The end floors force the travel direction before any decision looks ahead or behind.
    always_comb begin
      eDir = dir_q;
      if (int'(floor) == N_FLOOR - 1) eDir = 1'b0;
      else if (floor == '0)           eDir = 1'b1;
      ahead  = eDir ? above : below;
      behind = eDir ? below : above;
    end

    always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      arrPend_d = arrPend_q;
      enterDoor = 1'b0;
      fault_d   = !floorOk;

      if (!floorOk) begin
        state_d   = IDLE;
        cnt_d     = '0;
        arrPend_d = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            dir_d = eDir;
            if (here) begin
              enterDoor = 1'b1;
            end else if (ahead) begin
              state_d = MOVING;
            end else if (behind) begin
              dir_d   = !eDir;
              state_d = MOVING;
            end
          end
          MOVING: begin
            if (arrived) begin
              dir_d     = eDir;
              arrPend_d = 1'b0;
              if (cabHere || (eDir ? upHere : dnHere) || !ahead) enterDoor = 1'b1;
            end
          end
          DOOR: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              dir_d = eDir;
              if (ahead) begin
                state_d = MOVING;
              end else if (behind) begin
                dir_d   = !eDir;
                state_d = MOVING;
              end else begin
                state_d = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase

        if (enterDoor) begin
          state_d = DOOR;
          cnt_d   = CNT_W'(DWELL - 1);
        end

        // A second reversal right after a turn pulse is deferred one cycle; a pending arrival is kept.
        if (turn_q && (dir_d != dir_q)) begin
          state_d   = state_q;
          dir_d     = dir_q;
          cnt_d     = cnt_q;
          enterDoor = 1'b0;
          arrPend_d = (state_q == MOVING) && arrived;
        end
      end

      move_d = floorOk && (state_d == MOVING);
      door_d = floorOk && (state_d == DOOR);
      turn_d = floorOk && (dir_d != dir_q);

      clrUpLoc = '0;
      clrDnLoc = '0;
      for (int f = 0; f < N_FLOOR; f++) begin
        if (enterDoor && (f == int'(floor))) begin
          clrUpLoc[f] = dir_d & bus.up_passenger[f];
          clrDnLoc[f] = !dir_d & bus.down_passenger[f];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        dir_q     <= 1'b1;
        move_q    <= 1'b0;
        door_q    <= 1'b0;
        turn_q    <= 1'b0;
        fault_q   <= 1'b0;
        arrPend_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        state_q   <= state_d;
        dir_q     <= dir_d;
        move_q    <= move_d;
        door_q    <= door_d;
        turn_q    <= turn_d;
        fault_q   <= fault_d;
        arrPend_q <= arrPend_d;
        cnt_q     <= cnt_d;
      end
    end

    assign clrUpCar[c]      = clrUpLoc;
    assign clrDnCar[c]      = clrDnLoc;
    assign bus.dir[c]       = dir_q;
    assign bus.move[c]      = move_q;
    assign bus.door_open[c] = door_q;
    assign bus.turn[c]      = turn_q;
    assign bus.fault[c]     = fault_q;
  end

  always_comb begin
    clrUp_d = '0;
    clrDn_d = '0;
    for (int c = 0; c < N_CAR; c++) begin
      clrUp_d = clrUp_d | clrUpCar[c];
      clrDn_d = clrDn_d | clrDnCar[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clrUp_q <= '0;
      clrDn_q <= '0;
    end else begin
      clrUp_q <= clrUp_d;
      clrDn_q <= clrDn_d;
    end
  end

  assign bus.clr_up = clrUp_q;
  assign bus.clr_dn = clrDn_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Directed-vector bench for elevator_sched with two cars on seven floors, DWELL = 3.
module tb_elevator_sched;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  elevator_sched_if #(.N_FLOOR(7), .N_CAR(2), .FLOOR_W(3)) bus ();

  elevator_sched #(.N_FLOOR(7), .N_CAR(2), .FLOOR_W(3), .DWELL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs, take one rising edge, then settle before any check.
  task automatic applyStimulus(input logic [6:0] up, input logic [6:0] dn,
                               input logic [5:0] floors, input logic [13:0] cab,
                               input logic [1:0] arr);
    bus.up_passenger   = up;
    bus.down_passenger = dn;
    bus.curr_floor     = floors;
    bus.cab_call       = cab;
    bus.arrive         = arr;
    @(posedge clk);
    #1;
  endtask

  task automatic resetWith(input logic [5:0] floors);
    rst_n = 1'b0;
    applyStimulus(7'h0, 7'h0, floors, 14'h0, 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    bus.up_passenger   = '0;
    bus.down_passenger = '0;
    bus.curr_floor     = '0;
    bus.cab_call       = '0;
    bus.arrive         = '0;
    #1;

    // Car0 from floor 0 to an up-call at floor 4; car1 parked on an invalid floor
    resetWith({3'd7, 3'd0});
    checkOutput("rst_dir", 32'(bus.dir), 32'h3);
    checkOutput("rst_move", 32'(bus.move), 32'h0);
    checkOutput("rst_door", 32'(bus.door_open), 32'h0);
    checkOutput("rst_fault", 32'(bus.fault), 32'h0);
    checkOutput("rst_clr", 32'({bus.clr_up, bus.clr_dn}), 32'h0);
    applyStimulus(7'h10, 7'h0, {3'd7, 3'd0}, 14'h0, 2'b00);
    checkOutput("up4_move", 32'(bus.move), 32'h1);
    checkOutput("up4_dir", 32'(bus.dir), 32'h3);
    checkOutput("up4_turn", 32'(bus.turn), 32'h0);
    checkOutput("up4_fault1", 32'(bus.fault), 32'h2);
    applyStimulus(7'h10, 7'h0, {3'd7, 3'd4}, 14'h0, 2'b01);
    checkOutput("up4_door1", 32'(bus.door_open), 32'h1);
    checkOutput("up4_stop", 32'(bus.move), 32'h0);
    checkOutput("up4_clr", 32'(bus.clr_up), 32'h10);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd4}, 14'h0, 2'b00);
    checkOutput("up4_door2", 32'(bus.door_open), 32'h1);
    checkOutput("up4_clr_once", 32'(bus.clr_up), 32'h0);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd4}, 14'h0, 2'b00);
    checkOutput("up4_door3", 32'(bus.door_open), 32'h1);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd4}, 14'h0, 2'b00);
    checkOutput("up4_closed", 32'(bus.door_open), 32'h0);
    checkOutput("up4_idle", 32'(bus.move), 32'h0);

    // Car1 at floor 5 heading up, only a down-call below at floor 2
    resetWith({3'd5, 3'd7});
    applyStimulus(7'h0, 7'h04, {3'd5, 3'd7}, 14'h0, 2'b00);
    checkOutput("dn2_dir", 32'(bus.dir), 32'h1);
    checkOutput("dn2_turn", 32'(bus.turn), 32'h2);
    checkOutput("dn2_move", 32'(bus.move), 32'h2);
    applyStimulus(7'h0, 7'h04, {3'd5, 3'd7}, 14'h0, 2'b00);
    checkOutput("dn2_turn_off", 32'(bus.turn), 32'h0);
    checkOutput("dn2_still_moving", 32'(bus.move), 32'h2);
    applyStimulus(7'h0, 7'h04, {3'd2, 3'd7}, 14'h0, 2'b10);
    checkOutput("dn2_door", 32'(bus.door_open), 32'h2);
    checkOutput("dn2_clr", 32'(bus.clr_dn), 32'h04);
    checkOutput("dn2_clr_up", 32'(bus.clr_up), 32'h0);
    applyStimulus(7'h0, 7'h0, {3'd2, 3'd7}, 14'h0, 2'b00);
    checkOutput("dn2_clr_once", 32'(bus.clr_dn), 32'h0);
    applyStimulus(7'h0, 7'h0, {3'd2, 3'd7}, 14'h0, 2'b00);
    checkOutput("dn2_door3", 32'(bus.door_open), 32'h2);
    applyStimulus(7'h0, 7'h0, {3'd2, 3'd7}, 14'h0, 2'b00);
    checkOutput("dn2_closed", 32'(bus.door_open), 32'h0);
    checkOutput("dn2_dir_kept", 32'(bus.dir), 32'h1);

    // Car0 at the top floor with a cab call there: door opens, direction forced down
    resetWith({3'd7, 3'd6});
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0040, 2'b00);
    checkOutput("top_door", 32'(bus.door_open), 32'h1);
    checkOutput("top_dir", 32'(bus.dir), 32'h2);
    checkOutput("top_turn", 32'(bus.turn), 32'h1);
    checkOutput("top_move", 32'(bus.move), 32'h0);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0, 2'b00);
    checkOutput("top_turn_off", 32'(bus.turn), 32'h0);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0, 2'b00);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0, 2'b00);
    checkOutput("top_closed", 32'(bus.door_open), 32'h0);
    checkOutput("top_no_move", 32'(bus.move), 32'h0);
    checkOutput("top_dir_held", 32'(bus.dir), 32'h2);

    // Reset during the second door cycle, then idle with no calls
    resetWith({3'd7, 3'd6});
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0040, 2'b00);
    applyStimulus(7'h0, 7'h0, {3'd7, 3'd6}, 14'h0, 2'b00);
    checkOutput("mid_door_open", 32'(bus.door_open), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_door", 32'(bus.door_open), 32'h0);
    checkOutput("mid_rst_dir", 32'(bus.dir), 32'h3);
    checkOutput("mid_rst_fault", 32'(bus.fault), 32'h0);
    resetWith({3'd3, 3'd3});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(7'h0, 7'h0, {3'd3, 3'd3}, 14'h0, (i == 1) ? 2'b11 : 2'b00);
      checkOutput("idle_move", 32'(bus.move), 32'h0);
      checkOutput("idle_door", 32'(bus.door_open), 32'h0);
      checkOutput("idle_dir", 32'(bus.dir), 32'h3);
    end

    // Invalid floor on both cars, then car0 restored to floor 3 with a call at 5
    resetWith({3'd7, 3'd7});
    applyStimulus(7'h20, 7'h0, {3'd7, 3'd7}, 14'h0, 2'b00);
    checkOutput("flt_fault", 32'(bus.fault), 32'h3);
    checkOutput("flt_move", 32'(bus.move), 32'h0);
    applyStimulus(7'h20, 7'h0, {3'd7, 3'd3}, 14'h0, 2'b00);
    checkOutput("flt_restored", 32'(bus.fault), 32'h2);
    checkOutput("flt_dispatch", 32'(bus.move), 32'h1);

    // Both cars at floor 3 answer the same up-call
    resetWith({3'd3, 3'd3});
    applyStimulus(7'h08, 7'h0, {3'd3, 3'd3}, 14'h0, 2'b00);
    checkOutput("both_door", 32'(bus.door_open), 32'h3);
    checkOutput("both_clr", 32'(bus.clr_up), 32'h08);
    applyStimulus(7'h08, 7'h0, {3'd3, 3'd3}, 14'h0, 2'b00);
    checkOutput("both_clr_once", 32'(bus.clr_up), 32'h0);
    checkOutput("both_door2", 32'(bus.door_open), 32'h3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
